// File: rtl/fp_sub_pkg.sv
// Shared types and constants for the sequential FP magnitude subtractor.
package fp_sub_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int SIG_W  = 24;

    // Normalisation can never need more left shifts than significand bits below the hidden one.
    localparam int MAX_NORM_SHIFTS = 23;

    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam logic [31:0]      QNAN        = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SUB,
        NORM,
        DONE
    } state_t;

endpackage

// File: rtl/fp_subtractor_seq_if.sv
// Operand/result handshake bundle for the FP subtractor.
interface fp_subtractor_seq_if;
    import fp_sub_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [EXP_W+FRAC_W:0]     A;
    logic [EXP_W+FRAC_W:0]     B;
    logic                      out_valid;
    logic                      out_ready;
    logic [EXP_W+FRAC_W:0]     Out;

    // Producer/consumer side: drives operands, takes results.
    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, Out
    );

    // Subtractor side.
    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, Out
    );

endinterface

// File: rtl/fp_align_unit.sv
// Combinational operand alignment: flush denormals, order magnitudes,
// derive the result sign and right-shift the smaller significand.
module fp_align_unit
    import fp_sub_pkg::*;
(
    input  logic [EXP_W+FRAC_W-1:0] a_mag_i,
    input  logic [EXP_W+FRAC_W-1:0] b_mag_i,
    output logic                    sign_o,
    output logic [EXP_W-1:0]        exp_l_o,
    output logic [SIG_W-1:0]        sig_l_o,
    output logic [SIG_W-1:0]        sig_s_o
);

    logic [EXP_W-1:0] a_exp;
    logic [EXP_W-1:0] b_exp;
    logic [EXP_W-1:0] exp_s;
    logic [EXP_W-1:0] shift_d;
    logic [SIG_W-1:0] a_sig;
    logic [SIG_W-1:0] b_sig;
    logic [SIG_W-1:0] sig_s_raw;

    // Order operands by {exp, sig}; shifted-out bits are truncated, large shifts saturate to zero.
    always_comb begin
        a_exp = a_mag_i[EXP_W+FRAC_W-1:FRAC_W];
        b_exp = b_mag_i[EXP_W+FRAC_W-1:FRAC_W];
        a_sig = (a_exp == '0) ? '0 : {1'b1, a_mag_i[FRAC_W-1:0]};
        b_sig = (b_exp == '0) ? '0 : {1'b1, b_mag_i[FRAC_W-1:0]};

        if ({b_exp, b_sig} > {a_exp, a_sig}) begin
            sign_o    = 1'b1;
            exp_l_o   = b_exp;
            sig_l_o   = b_sig;
            exp_s     = a_exp;
            sig_s_raw = a_sig;
        end else begin
            sign_o    = 1'b0;
            exp_l_o   = a_exp;
            sig_l_o   = a_sig;
            exp_s     = b_exp;
            sig_s_raw = b_sig;
        end

        shift_d = exp_l_o - exp_s;
        if (shift_d >= EXP_W'(SIG_W)) begin
            sig_s_o = '0;
        end else begin
            sig_s_o = sig_s_raw >> shift_d;
        end
    end

endmodule

// File: rtl/fp_subtractor_seq.sv
// Multi-cycle single-precision magnitude subtractor: Out = |A| - |B|.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   ALIGN | special-operand check, magnitude order, align smaller operand
//   SUB   | subtract aligned significands
//   NORM  | left-shift out leading zeros, one bit per cycle
//   DONE  | result held on Out with out_valid until out_ready
module fp_subtractor_seq
    import fp_sub_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    fp_subtractor_seq_if.slave   bus
);

    state_t                  state_q;
    logic [EXP_W+FRAC_W-1:0] a_q;
    logic [EXP_W+FRAC_W-1:0] b_q;
    logic                    sign_q;
    logic [EXP_W-1:0]        exp_q;
    logic [SIG_W-1:0]        sig_l_q;
    logic [SIG_W-1:0]        sig_s_q;
    logic [SIG_W-1:0]        mant_q;
    logic [4:0]              shift_cnt_q;
    logic [31:0]             out_q;
    logic                    out_valid_q;
    logic                    in_ready_q;

    logic                    special_d;
    logic [SIG_W-1:0]        diff_d;
    logic                    al_sign;
    logic [EXP_W-1:0]        al_exp_l;
    logic [SIG_W-1:0]        al_sig_l;
    logic [SIG_W-1:0]        al_sig_s;

    fp_align_unit u_align (
        .a_mag_i (a_q),
        .b_mag_i (b_q),
        .sign_o  (al_sign),
        .exp_l_o (al_exp_l),
        .sig_l_o (al_sig_l),
        .sig_s_o (al_sig_s)
    );

    // Special-operand detect and significand difference from latched/aligned operands.
    always_comb begin
        special_d = (a_q[EXP_W+FRAC_W-1:FRAC_W] == EXP_SPECIAL) ||
                    (b_q[EXP_W+FRAC_W-1:FRAC_W] == EXP_SPECIAL);
        diff_d    = sig_l_q - sig_s_q;
    end

    // Sequencer FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            sig_l_q     <= '0;
            sig_s_q     <= '0;
            mant_q      <= '0;
            shift_cnt_q <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_q        <= bus.A[EXP_W+FRAC_W-1:0];
                        b_q        <= bus.B[EXP_W+FRAC_W-1:0];
                        in_ready_q <= 1'b0;
                        state_q    <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (special_d) begin
                        out_q       <= QNAN;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        sign_q  <= al_sign;
                        exp_q   <= al_exp_l;
                        sig_l_q <= al_sig_l;
                        sig_s_q <= al_sig_s;
                        state_q <= SUB;
                    end
                end
                SUB: begin
                    mant_q      <= diff_d;
                    shift_cnt_q <= 5'(MAX_NORM_SHIFTS);
                    state_q     <= NORM;
                end
                NORM: begin
                    if (mant_q == '0) begin
                        out_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (mant_q[SIG_W-1]) begin
                        out_q       <= {sign_q, exp_q, mant_q[FRAC_W-1:0]};
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (exp_q == EXP_W'(1) || shift_cnt_q == '0) begin
                        // Underflow flushes to zero; the shift budget only guards against runaway.
                        out_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        mant_q      <= mant_q << 1;
                        exp_q       <= exp_q - EXP_W'(1);
                        shift_cnt_q <= shift_cnt_q - 5'd1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Out       = out_q;

endmodule

// File: tb/tb_fp_subtractor_seq.sv
// Directed bench for fp_subtractor_seq with an arithmetic reference model.
module tb_fp_subtractor_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_subtractor_seq_if bus ();

    fp_subtractor_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Shared between driver and compare process.
    bit          busy    = 1'b0;
    bit          seen    = 1'b0;
    int          acc_cyc = 0;
    logic [31:0] exp_out = '0;
    int          exp_lat = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the rules, leading-one search for the shift count.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] o, output int lat);
        int          ea, eb, el, es, d, k, p;
        longint      ma, mb, ml, ms, mant;
        bit          sgn;
        logic [23:0] nm;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            o = 32'h7FC0_0000;
            lat = 1;
            return;
        end
        ma = (ea == 0) ? 0 : longint'(a[22:0]) + 64'd8388608;
        mb = (eb == 0) ? 0 : longint'(b[22:0]) + 64'd8388608;
        if (longint'(eb) * 16777216 + mb > longint'(ea) * 16777216 + ma) begin
            sgn = 1'b1; el = eb; ml = mb; es = ea; ms = ma;
        end else begin
            sgn = 1'b0; el = ea; ml = ma; es = eb; ms = mb;
        end
        d = el - es;
        ms = (d >= 24) ? 0 : (ms >> d);
        mant = ml - ms;
        if (mant == 0) begin
            o = 32'h0;
            lat = 3;
            return;
        end
        p = -1;
        for (int i = 0; i < 24; i++) if (mant[i]) p = i;
        k = 23 - p;
        if (el - k >= 1) begin
            nm = 24'(mant << k);
            o = {sgn, 8'(el - k), nm[22:0]};
            lat = 3 + k;
        end else begin
            o = 32'h0;
            lat = 3 + (el - 1);
        end
    endfunction

    // Compare process: while an operation is in flight, check handshake and result every cycle.
    always @(negedge clk) begin
        if (busy) begin
            chk("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
            if (bus.out_valid) begin
                chk("out_value", bus.Out, exp_out);
                if (!seen) begin
                    chk("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
                    seen = 1'b1;
                end
            end else if (seen) begin
                chk("out_valid_held", 32'd0, 32'd1);
            end
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        int t;
        model(a, b, exp_out, exp_lat);
        seen = 1'b0;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        busy = 1'b1;
        bus.in_valid = 1'b0;
        bus.A = $urandom;
        bus.B = $urandom;
        t = 0;
        while (!bus.out_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) begin
            chk("result_timeout", 32'd0, 32'd1);
            busy = 1'b0;
            return;
        end
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        busy = 1'b0;
        chk("out_valid_after_hs", {31'b0, bus.out_valid}, 32'd0);
        chk("in_ready_after_hs", {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] mo;
        int          ml;

        vecs[0]  = '{32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3, 0};
        vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, 32'hC000_0000, 3, 0};
        vecs[2]  = '{32'h4120_0000, 32'h4120_0000, 32'h0000_0000, 3, 0};
        vecs[3]  = '{32'h3FC0_0000, 32'h3F80_0000, 32'h3F00_0000, 4, 0};
        vecs[4]  = '{32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 26, 0};
        vecs[5]  = '{32'h4B80_0000, 32'h3F80_0000, 32'h4B80_0000, 3, 0};
        vecs[6]  = '{32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1, 0};
        vecs[7]  = '{32'h3F80_0000, 32'hFFC0_0000, 32'h7FC0_0000, 1, 2};
        vecs[8]  = '{32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 3, 0};
        vecs[9]  = '{32'h0000_0000, 32'h3F80_0000, 32'hBF80_0000, 3, 0};
        vecs[10] = '{32'hC040_0000, 32'hBF80_0000, 32'h4000_0000, 3, 5};
        vecs[11] = '{32'h0100_0001, 32'h0100_0000, 32'h0000_0000, 4, 0};
        vecs[12] = '{32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 3, 0};
        vecs[13] = '{32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE, 4, 0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.A         = '0;
        bus.B         = '0;

        // Hand-computed values pin the reference model.
        foreach (vecs[i]) begin
            model(vecs[i].a, vecs[i].b, mo, ml);
            chk($sformatf("model_out_%0d", i), mo, vecs[i].out);
            chk($sformatf("model_lat_%0d", i), 32'(ml), 32'(vecs[i].lat));
        end

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_out", bus.Out, 32'h0);
        chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].hold);

        // Reset while normalising a long-shift result: the result is lost.
        @(negedge clk);
        bus.A = 32'h3F80_0001;
        bus.B = 32'h3F80_0000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("midnorm_in_ready", {31'b0, bus.in_ready}, 32'd0);
        repeat (6) @(negedge clk);
        chk("midnorm_out_valid", {31'b0, bus.out_valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_norm_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_norm_out", bus.Out, 32'h0);
        chk("rst_norm_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (30) @(negedge clk);
        chk("rst_norm_no_result", {31'b0, bus.out_valid}, 32'd0);

        run_op(32'h3FC0_0000, 32'h3F80_0000, 1);
        run_op(32'h4040_0000, 32'h3F80_0000, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fp_subtractor_seq.md
Name: fp_subtractor_seq

Overview:
- Multi-cycle single-precision (IEEE-754 layout) subtractor computing A − B on operand magnitudes.
- It is the inverse-direction companion to the team's combinational positive-only adder. Where the adder normalises by right-shifting on carry-out, this block normalises by left-shifting out leading zeros, one bit per cycle.
- Sits beside the adder in the FP datapath, behind a valid/ready handshake on both sides.

Parameters:
- MAX_NORM_SHIFTS, 23: upper bound on normalisation iterations. Fixed by the 24-bit significand.
- QNAN, 32'h7FC0_0000: value output for any special-operand input.

Ports:
- clk  input  1  sole clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands A, B are presented.
- in_ready  output  1  block can accept operands. High only in IDLE.
- A  input  32  minuend. Sign bit [31] is ignored; the magnitude is used.
- B  input  32  subtrahend. Sign bit [31] is ignored; the magnitude is used.
- out_valid  output  1  Out holds a completed result.
- out_ready  input  1  consumer accepts Out.
- Out  output  32  result {sign, exp[7:0], frac[22:0]}.

Behaviour:
- Reset (synchronous, rst=1 at a rising clk edge): state goes to IDLE, out_valid=0, Out=32'h0, in_ready=1 after the edge. Any in-flight operation is discarded; reset mid-NORM or mid-DONE loses the result.
- Accept on the edge where in_valid && in_ready. Operands are latched; the A, B inputs are don't-care afterwards.
- States:
  - IDLE: wait for accept → ALIGN.
  - ALIGN (1 cycle), in order:
    - If either exponent is 8'hFF: result = QNAN → DONE.
    - An exponent of 0 makes that operand zero (denormals flushed). Otherwise the significand is {1, frac} (24 bits).
    - Compare magnitudes {exp, sig}. Swap so L ≥ S; sign = 1 iff |B| > |A|.
    - Right-shift S by d = expL − expS. If d ≥ 24, the aligned S is 0. Shifted-out bits are truncated (no guard/round/sticky, matching the adder).
    - → SUB.
  - SUB (1 cycle): mant = sigL − sigS_aligned (24-bit, never negative); exp = expL → NORM.
  - NORM, evaluated each cycle in this priority:
    - mant == 0 → Out = 32'h0 (sign forced to 0) → DONE.
    - mant[23] == 1 → Out = {sign, exp, mant[22:0]} → DONE.
    - exp == 1 with mant[23] == 0 → underflow, Out = 32'h0 → DONE.
    - Otherwise mant <<= 1, exp −= 1, stay in NORM.
  - DONE: out_valid = 1. Out and out_valid are held stable until out_ready. On the edge with out_valid && out_ready → IDLE, out_valid = 0.
- Latency: with accept at edge T0, out_valid rises after edge T(3+k), where k = left shifts performed (0..23). Special operands: after edge T1.
- Throughput: one operation in flight. in_ready = 0 from accept until the DONE handshake completes. There is no IDLE bypass: the next accept happens at the earliest 1 cycle after the handshake.
- Simultaneous rst and any handshake: rst wins.
- Overflow is impossible, since the result exponent is ≤ expL.

Decomposition:
- Shared package fp_sub_pkg contains:
  - state enum IDLE/ALIGN/SUB/NORM/DONE;
  - field widths EXP_W=8, FRAC_W=23, SIG_W=24;
  - EXP_SPECIAL=8'hFF and QNAN.
- One sub-module, fp_align_unit (combinational): magnitude compare, swap, sign, and saturating right shift (d ≥ 24 → 0). The FSM, subtract and normalise stay in the top.

Test Plan:
- A=0x40400000 (3.0), B=0x3F800000 (1.0) → Out=0x40000000; out_valid 3 cycles after accept; in_ready low throughout.
- A=0x3F800000, B=0x40400000 → Out=0xC0000000 (sign set by magnitude swap); A=0x41200000, B=0x41200000 → Out=0x00000000, k=0.
- A=0x3FC00000 (1.5), B=0x3F800000 → Out=0x3F000000 after 4 cycles; A=0x3F800001, B=0x3F800000 → Out=0x34000000 after 26 cycles (k=23).
- A=0x4B800000 (2^24), B=0x3F800000 (d=24) → Out=0x4B800000; A=0x7F800000, any B → Out=0x7FC00000 after 1 cycle.
- A=0x00800001, B=0x00800000 → underflow flush, Out=0x00000000; A=0x00000000, B=0x3F800000 → Out=0xBF800000.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → Out/out_valid stable, in_ready=0. Assert rst mid-NORM → next cycle IDLE, out_valid=0, Out=0, in_ready=1, then a fresh op completes correctly.
